// File: rtl/wf_pending_tracker_pkg.sv
// Shared sizing for the wavefront pending tracker.
package wf_pending_tracker_pkg;
  localparam int WF_PER_CU       = 40;
  localparam int WF_ID_LENGTH    = 6;
  localparam int ALU_CNT_W       = 2;
  localparam int LSU_CNT_W       = 4;
  localparam int ALU_MAX_PENDING = (1 << ALU_CNT_W) - 1;
  localparam int LSU_MAX_PENDING = (1 << LSU_CNT_W) - 1;
endpackage

// File: rtl/decoder_6b_40b_en.sv
// 6-bit id to 40-bit one-hot, gated by enable. Ids 40..63 decode to zero.
module decoder_6b_40b_en (
  input  logic [5:0]  addr_in,
  input  logic        en,
  output logic [39:0] out
);
  // one-hot decode; out-of-range ids match no bit
  always_comb begin
    out = '0;
    for (int i = 0; i < 40; i++)
      out[i] = en && (addr_in == 6'(i));
  end
endmodule

// File: rtl/wf_pending_tracker_counter.sv
// Saturating up/down pending counter for one wavefront slot and one unit.
module wf_pending_counter #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic room,
  output logic zero,
  output logic ovf,
  output logic unf
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt;

  assign room = (cnt != MAX);
  assign zero = (cnt == '0);
  // error pulses only for a lone inc/dec that cannot move the count;
  // a clear swallows the event silently
  assign ovf  = inc & ~dec & ~clr & ~room;
  assign unf  = dec & ~inc & ~clr & zero;

  // clear beats inc/dec; inc+dec together cancel; saturate at both ends
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && !dec && room)
      cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero)
      cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/wf_pending_tracker.sv
// Per-wavefront outstanding-instruction tracker feeding issue readiness.
// All outputs decode registered state only.
module wf_pending_tracker
  import wf_pending_tracker_pkg::*;
#(
  parameter int WF_N  = WF_PER_CU,
  parameter int ID_W  = WF_ID_LENGTH,
  parameter int ALU_W = ALU_CNT_W,
  parameter int LSU_W = LSU_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issued_valid,
  input  logic [ID_W-1:0] issued_wfid,
  input  logic            issued_lsu,
  input  logic            alu_retire_valid,
  input  logic [ID_W-1:0] alu_retire_wfid,
  input  logic            lsu_retire_valid,
  input  logic [ID_W-1:0] lsu_retire_wfid,
  input  logic            wf_clear_valid,
  input  logic [ID_W-1:0] wf_clear_wfid,
  output logic [WF_N-1:0] alu_room,
  output logic [WF_N-1:0] lsu_room,
  output logic [WF_N-1:0] wf_drained,
  output logic            overflow_err,
  output logic            underflow_err
);
  logic [WF_N-1:0] iss_oh, alu_ret_oh, lsu_ret_oh, clr_oh;
  logic [WF_N-1:0] alu_inc, lsu_inc;
  logic [WF_N-1:0] alu_zero, lsu_zero;
  logic [WF_N-1:0] alu_ovf, lsu_ovf, alu_unf, lsu_unf;

  decoder_6b_40b_en u_dec_iss  (.addr_in(issued_wfid),     .en(issued_valid),     .out(iss_oh));
  decoder_6b_40b_en u_dec_aret (.addr_in(alu_retire_wfid), .en(alu_retire_valid), .out(alu_ret_oh));
  decoder_6b_40b_en u_dec_lret (.addr_in(lsu_retire_wfid), .en(lsu_retire_valid), .out(lsu_ret_oh));
  decoder_6b_40b_en u_dec_clr  (.addr_in(wf_clear_wfid),   .en(wf_clear_valid),   .out(clr_oh));

  // steer the single issue port to one unit group
  assign alu_inc = issued_lsu ? '0 : iss_oh;
  assign lsu_inc = issued_lsu ? iss_oh : '0;

  wf_pending_counter #(.W(ALU_W)) u_alu_cnt [WF_N-1:0] (
    .clk(clk), .rst(rst), .inc(alu_inc), .dec(alu_ret_oh), .clr(clr_oh),
    .room(alu_room), .zero(alu_zero), .ovf(alu_ovf), .unf(alu_unf)
  );

  wf_pending_counter #(.W(LSU_W)) u_lsu_cnt [WF_N-1:0] (
    .clk(clk), .rst(rst), .inc(lsu_inc), .dec(lsu_ret_oh), .clr(clr_oh),
    .room(lsu_room), .zero(lsu_zero), .ovf(lsu_ovf), .unf(lsu_unf)
  );

  assign wf_drained = alu_zero & lsu_zero;

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= overflow_err  | (|alu_ovf) | (|lsu_ovf);
      underflow_err <= underflow_err | (|alu_unf) | (|lsu_unf);
    end
  end
endmodule
